// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundles every non-clock/reset signal of the ID/EX stage.
//   master : decode / pipeline-control side (drives decode inputs, reads stage outputs)
//   slave  : id_ex_stage itself
// Signals:
//   decode slot    : in_valid, rs_data, rt_data, imm, rs, rt, rd, alu_op, funct,
//                    alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg
//   control        : hold, flush
//   forwarding     : exm_reg_write/exm_rd/exm_result, wb_reg_write/wb_rd/wb_result
//   stage outputs  : A, B, ALUcontrol, store_data, dest, out_valid, out_reg_write,
//                    out_mem_read, out_mem_write, out_mem_to_reg, hazard_stall, illegal_funct
interface id_ex_stage_if;
   logic        in_valid;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] imm;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic        alu_src;
   logic        reg_dst;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic        hold;
   logic        flush;
   logic        exm_reg_write;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;

   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  ALUcontrol;
   logic [31:0] store_data;
   logic [4:0]  dest;
   logic        out_valid;
   logic        out_reg_write;
   logic        out_mem_read;
   logic        out_mem_write;
   logic        out_mem_to_reg;
   logic        hazard_stall;
   logic        illegal_funct;

   modport master (
      output in_valid, rs_data, rt_data, imm, rs, rt, rd, alu_op, funct,
             alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
             hold, flush, exm_reg_write, exm_rd, exm_result,
             wb_reg_write, wb_rd, wb_result,
      input  A, B, ALUcontrol, store_data, dest, out_valid, out_reg_write,
             out_mem_read, out_mem_write, out_mem_to_reg, hazard_stall, illegal_funct
   );

   modport slave (
      input  in_valid, rs_data, rt_data, imm, rs, rt, rd, alu_op, funct,
             alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
             hold, flush, exm_reg_write, exm_rd, exm_result,
             wb_reg_write, wb_rd, wb_result,
      output A, B, ALUcontrol, store_data, dest, out_valid, out_reg_write,
             out_mem_read, out_mem_write, out_mem_to_reg, hazard_stall, illegal_funct
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, ALU-control
// decode, load-use hazard detection, hold and flush.
//   clk : pipeline clock, rising edge
//   rst : asynchronous active-high reset
//   bus : id_ex_stage_if.slave -- decode inputs, forwarding candidates,
//         hold/flush, registered ALU operands/controls, combinational hazard_stall
module id_ex_stage (
   input logic         clk,
   input logic         rst,
   id_ex_stage_if.slave bus
);

   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;
   logic [3:0]  ctl_d;
   logic        bad_funct;
   logic        hazard;

   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [3:0]  ctl_q;
   logic [31:0] sd_q;
   logic [4:0]  dest_q;
   logic        vld_q;
   logic        rw_q;
   logic        mr_q;
   logic        mw_q;
   logic        m2r_q;
   logic        ill_q;

   // EX/MEM is the newer result, so it beats MEM/WB; $0 is never forwarded.
   always_comb begin
      fwd_rs = bus.rs_data;
      if (bus.exm_reg_write && bus.exm_rd == bus.rs && bus.rs != '0)
         fwd_rs = bus.exm_result;
      else if (bus.wb_reg_write && bus.wb_rd == bus.rs && bus.rs != '0)
         fwd_rs = bus.wb_result;
   end

   always_comb begin
      fwd_rt = bus.rt_data;
      if (bus.exm_reg_write && bus.exm_rd == bus.rt && bus.rt != '0)
         fwd_rt = bus.exm_result;
      else if (bus.wb_reg_write && bus.wb_rd == bus.rt && bus.rt != '0)
         fwd_rt = bus.wb_result;
   end

   always_comb begin
      ctl_d     = 4'b0010;
      bad_funct = 1'b0;
      case (bus.alu_op)
         2'b00: ctl_d = 4'b0010;
         2'b01: ctl_d = 4'b0110;
         2'b11: ctl_d = 4'b0111;
         default: begin
            case (bus.funct)
               6'b100000: ctl_d = 4'b0010;
               6'b100010: ctl_d = 4'b0110;
               6'b100100: ctl_d = 4'b0000;
               6'b100101: ctl_d = 4'b0001;
               6'b101010: ctl_d = 4'b0111;
               default: begin
                  ctl_d     = 4'b0010;
                  bad_funct = 1'b1;
               end
            endcase
         end
      endcase
   end

   // rt only matters as a source when it is read as an ALU operand or as store data.
   assign hazard = vld_q && mr_q && bus.in_valid && dest_q != '0 &&
                   (dest_q == bus.rs ||
                    (dest_q == bus.rt && (!bus.alu_src || bus.mem_write)));

   // Priority rst > flush > hold > hazard bubble > capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || bus.flush || (!bus.hold && hazard)) begin
         a_q    <= '0;
         b_q    <= '0;
         ctl_q  <= '0;
         sd_q   <= '0;
         dest_q <= '0;
         vld_q  <= 1'b0;
         rw_q   <= 1'b0;
         mr_q   <= 1'b0;
         mw_q   <= 1'b0;
         m2r_q  <= 1'b0;
         ill_q  <= 1'b0;
      end else if (!bus.hold) begin
         a_q    <= fwd_rs;
         b_q    <= bus.alu_src ? bus.imm : fwd_rt;
         ctl_q  <= ctl_d;
         sd_q   <= fwd_rt;
         dest_q <= bus.reg_dst ? bus.rd : bus.rt;
         vld_q  <= bus.in_valid;
         rw_q   <= bus.in_valid & bus.reg_write;
         mr_q   <= bus.in_valid & bus.mem_read;
         mw_q   <= bus.in_valid & bus.mem_write;
         m2r_q  <= bus.mem_to_reg;
         ill_q  <= bus.in_valid & (bus.alu_op == 2'b10) & bad_funct;
      end
   end

   assign bus.A              = a_q;
   assign bus.B              = b_q;
   assign bus.ALUcontrol     = ctl_q;
   assign bus.store_data     = sd_q;
   assign bus.dest           = dest_q;
   assign bus.out_valid      = vld_q;
   assign bus.out_reg_write  = rw_q;
   assign bus.out_mem_read   = mr_q;
   assign bus.out_mem_write  = mw_q;
   assign bus.out_mem_to_reg = m2r_q;
   assign bus.hazard_stall   = hazard;
   assign bus.illegal_funct  = ill_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        in_valid;
      logic [1:0]  alu_op;
      logic [5:0]  funct;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rs_data, rt_data, imm;
      logic        alu_src, reg_dst, reg_write;
      logic        exm_we;
      logic [4:0]  exm_rd;
      logic [31:0] exm_res;
      logic        wb_we;
      logic [4:0]  wb_rd;
      logic [31:0] wb_res;
      logic [31:0] e_a, e_b, e_sd;
      logic [3:0]  e_ctl;
      logic        e_ill;
      logic [4:0]  e_dest;
      logic        e_vld, e_rw;
   } vec_t;

   vec_t v [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.in_valid = 0; bus.rs_data = '0; bus.rt_data = '0; bus.imm = '0;
      bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.alu_op = '0; bus.funct = '0;
      bus.alu_src = 0; bus.reg_dst = 0; bus.reg_write = 0; bus.mem_read = 0;
      bus.mem_write = 0; bus.mem_to_reg = 0; bus.hold = 0; bus.flush = 0;
      bus.exm_reg_write = 0; bus.exm_rd = '0; bus.exm_result = '0;
      bus.wb_reg_write = 0; bus.wb_rd = '0; bus.wb_result = '0;
   endtask

   // R-type add rs=1, rt=2, rd=3 with the given register data.
   task automatic drive_add(input logic [31:0] a, input logic [31:0] b);
      clear_inputs();
      bus.in_valid = 1; bus.alu_op = 2'b10; bus.funct = 6'b100000;
      bus.rs = 5'd1; bus.rt = 5'd2; bus.rd = 5'd3; bus.reg_dst = 1; bus.reg_write = 1;
      bus.rs_data = a; bus.rt_data = b;
   endtask

   // lw $dst, 8($1)
   task automatic drive_lw(input logic [4:0] dst);
      clear_inputs();
      bus.in_valid = 1; bus.alu_op = 2'b00; bus.rs = 5'd1; bus.rt = dst;
      bus.alu_src = 1; bus.imm = 32'd8; bus.mem_read = 1; bus.reg_write = 1;
      bus.mem_to_reg = 1; bus.rs_data = 32'h100;
   endtask

   initial begin
      // in_v op    funct     rs rt rd rs_data        rt_data        imm            src dst rw  exm                    wb                    A              B              SD             ctl      ill dest vld rw
      v[0]  = '{1, 2'b10, 6'h20, 1, 2, 3, 32'd5,         32'd7,         32'd0,         0, 1, 1, 0, 0, 32'd0,         0, 0, 32'd0,      32'd5,         32'd7,         32'd7,         4'b0010, 0, 3, 1, 1};
      v[1]  = '{1, 2'b10, 6'h24, 1, 2, 3, 32'hF0F0,      32'h0FF0,      32'd0,         0, 1, 1, 0, 0, 32'd0,         0, 0, 32'd0,      32'hF0F0,      32'h0FF0,      32'h0FF0,      4'b0000, 0, 3, 1, 1};
      v[2]  = '{1, 2'b10, 6'h25, 1, 2, 3, 32'hF0F0,      32'h0FF0,      32'd0,         0, 1, 1, 0, 0, 32'd0,         0, 0, 32'd0,      32'hF0F0,      32'h0FF0,      32'h0FF0,      4'b0001, 0, 3, 1, 1};
      v[3]  = '{1, 2'b10, 6'h22, 1, 2, 3, 32'd9,         32'd4,         32'd0,         0, 1, 1, 0, 0, 32'd0,         0, 0, 32'd0,      32'd9,         32'd4,         32'd4,         4'b0110, 0, 3, 1, 1};
      v[4]  = '{1, 2'b10, 6'h2A, 1, 2, 3, 32'd9,         32'd4,         32'd0,         0, 1, 1, 0, 0, 32'd0,         0, 0, 32'd0,      32'd9,         32'd4,         32'd4,         4'b0111, 0, 3, 1, 1};
      v[5]  = '{1, 2'b10, 6'h3F, 1, 2, 3, 32'd9,         32'd4,         32'd0,         0, 1, 1, 0, 0, 32'd0,         0, 0, 32'd0,      32'd9,         32'd4,         32'd4,         4'b0010, 1, 3, 1, 1};
      v[6]  = '{1, 2'b00, 6'h00, 1, 2, 3, 32'd5,         32'd7,         32'h10,        1, 0, 1, 0, 0, 32'd0,         0, 0, 32'd0,      32'd5,         32'h10,        32'd7,         4'b0010, 0, 2, 1, 1};
      v[7]  = '{1, 2'b01, 6'h00, 1, 2, 3, 32'd5,         32'd7,         32'h10,        0, 0, 0, 0, 0, 32'd0,         0, 0, 32'd0,      32'd5,         32'd7,         32'd7,         4'b0110, 0, 2, 1, 0};
      v[8]  = '{1, 2'b11, 6'h00, 1, 2, 3, 32'd5,         32'd7,         32'hFFFFFFFF,  1, 0, 1, 0, 0, 32'd0,         0, 0, 32'd0,      32'd5,         32'hFFFFFFFF,  32'd7,         4'b0111, 0, 2, 1, 1};
      v[9]  = '{1, 2'b10, 6'h20, 3, 2, 3, 32'h11,        32'd7,         32'd0,         0, 1, 1, 1, 3, 32'hAAAA0000,  1, 3, 32'h5555,   32'hAAAA0000,  32'd7,         32'd7,         4'b0010, 0, 3, 1, 1};
      v[10] = '{1, 2'b10, 6'h20, 3, 2, 3, 32'h11,        32'd7,         32'd0,         0, 1, 1, 0, 3, 32'hAAAA0000,  1, 3, 32'h5555,   32'h5555,      32'd7,         32'd7,         4'b0010, 0, 3, 1, 1};
      v[11] = '{1, 2'b10, 6'h20, 0, 2, 3, 32'h77,        32'd7,         32'd0,         0, 1, 1, 1, 0, 32'hAAAA0000,  1, 0, 32'h5555,   32'h77,        32'd7,         32'd7,         4'b0010, 0, 3, 1, 1};
      v[12] = '{1, 2'b00, 6'h00, 1, 2, 3, 32'd5,         32'd7,         32'd4,         1, 0, 0, 1, 2, 32'hCAFE,      1, 2, 32'hBEEF,   32'd5,         32'd4,         32'hCAFE,      4'b0010, 0, 2, 1, 0};
      v[13] = '{0, 2'b10, 6'h20, 1, 2, 3, 32'd5,         32'd7,         32'd0,         0, 1, 1, 0, 0, 32'd0,         0, 0, 32'd0,      32'd5,         32'd7,         32'd7,         4'b0010, 0, 3, 0, 0};
      v[14] = '{1, 2'b00, 6'h3F, 1, 2, 3, 32'd5,         32'd7,         32'd0,         0, 1, 1, 0, 0, 32'd0,         0, 0, 32'd0,      32'd5,         32'd7,         32'd7,         4'b0010, 0, 3, 1, 1};

      clear_inputs();
      #12 rst = 1'b0;
      chk("init_out_valid", {31'b0, bus.out_valid}, 32'd0);

      // Table-driven decode / forwarding sweep.
      for (int i = 0; i < 15; i++) begin
         clear_inputs();
         bus.in_valid = v[i].in_valid; bus.alu_op = v[i].alu_op; bus.funct = v[i].funct;
         bus.rs = v[i].rs; bus.rt = v[i].rt; bus.rd = v[i].rd;
         bus.rs_data = v[i].rs_data; bus.rt_data = v[i].rt_data; bus.imm = v[i].imm;
         bus.alu_src = v[i].alu_src; bus.reg_dst = v[i].reg_dst; bus.reg_write = v[i].reg_write;
         bus.exm_reg_write = v[i].exm_we; bus.exm_rd = v[i].exm_rd; bus.exm_result = v[i].exm_res;
         bus.wb_reg_write = v[i].wb_we; bus.wb_rd = v[i].wb_rd; bus.wb_result = v[i].wb_res;
         step();
         chk($sformatf("v%0d_A", i), bus.A, v[i].e_a);
         chk($sformatf("v%0d_B", i), bus.B, v[i].e_b);
         chk($sformatf("v%0d_store_data", i), bus.store_data, v[i].e_sd);
         chk($sformatf("v%0d_ALUcontrol", i), {28'b0, bus.ALUcontrol}, {28'b0, v[i].e_ctl});
         chk($sformatf("v%0d_illegal", i), {31'b0, bus.illegal_funct}, {31'b0, v[i].e_ill});
         chk($sformatf("v%0d_dest", i), {27'b0, bus.dest}, {27'b0, v[i].e_dest});
         chk($sformatf("v%0d_out_valid", i), {31'b0, bus.out_valid}, {31'b0, v[i].e_vld});
         chk($sformatf("v%0d_out_reg_write", i), {31'b0, bus.out_reg_write}, {31'b0, v[i].e_rw});
      end

      // Async reset mid-cycle: outputs clear without a clock edge.
      #2 rst = 1'b1;
      #1;
      chk("rst_A", bus.A, 32'd0);
      chk("rst_B", bus.B, 32'd0);
      chk("rst_store_data", bus.store_data, 32'd0);
      chk("rst_ctl_dest", {23'b0, bus.ALUcontrol, bus.dest}, 32'd0);
      chk("rst_controls", {26'b0, bus.out_valid, bus.out_reg_write, bus.out_mem_read,
                           bus.out_mem_write, bus.out_mem_to_reg, bus.illegal_funct}, 32'd0);
      #1 rst = 1'b0;
      drive_add(32'd5, 32'd7);
      step();
      chk("post_rst_A", bus.A, 32'd5);
      chk("post_rst_B", bus.B, 32'd7);
      chk("post_rst_ctl", {28'b0, bus.ALUcontrol}, 32'h2);
      chk("post_rst_valid", {31'b0, bus.out_valid}, 32'd1);

      // Hold freezes the stage for 3 cycles despite new inputs.
      drive_add(32'd99, 32'd98);
      bus.hold = 1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("hold%0d_A", c), bus.A, 32'd5);
         chk($sformatf("hold%0d_B", c), bus.B, 32'd7);
         chk($sformatf("hold%0d_valid", c), {31'b0, bus.out_valid}, 32'd1);
      end
      bus.flush = 1;
      step();
      chk("flush_hold_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("flush_hold_rw", {31'b0, bus.out_reg_write}, 32'd0);
      chk("flush_hold_A", bus.A, 32'd0);

      // Load-use: lw $4 then add $5,$4,$2.
      drive_lw(5'd4);
      step();
      chk("lw_mem_read", {31'b0, bus.out_mem_read}, 32'd1);
      chk("lw_dest", {27'b0, bus.dest}, 32'd4);
      drive_add(32'hDEAD, 32'd7);
      bus.rs = 5'd4; bus.rd = 5'd5;
      #1;
      chk("lu_hazard", {31'b0, bus.hazard_stall}, 32'd1);
      step();
      chk("lu_bubble_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("lu_bubble_rw", {31'b0, bus.out_reg_write}, 32'd0);
      chk("lu_hazard_gone", {31'b0, bus.hazard_stall}, 32'd0);
      bus.wb_reg_write = 1; bus.wb_rd = 5'd4; bus.wb_result = 32'h1234;
      step();
      chk("lu_add_A", bus.A, 32'h1234);
      chk("lu_add_B", bus.B, 32'd7);
      chk("lu_add_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("lu_add_dest", {27'b0, bus.dest}, 32'd5);

      // Hazard under hold: hold wins, then flush beats hazard.
      drive_lw(5'd6);
      step();
      clear_inputs();
      bus.in_valid = 1; bus.alu_op = 2'b00; bus.rs = 5'd1; bus.rt = 5'd6;
      bus.alu_src = 1; bus.mem_write = 1; bus.imm = 32'd4; bus.rs_data = 32'h200;
      bus.hold = 1;
      #1;
      chk("hold_hz_stall", {31'b0, bus.hazard_stall}, 32'd1);
      step();
      chk("hold_hz_frozen_mr", {31'b0, bus.out_mem_read}, 32'd1);
      chk("hold_hz_frozen_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("hold_hz_still", {31'b0, bus.hazard_stall}, 32'd1);
      bus.hold = 0; bus.flush = 1;
      step();
      chk("flush_hz_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("flush_hz_mem_write", {31'b0, bus.out_mem_write}, 32'd0);
      bus.flush = 0;
      step();
      chk("sw_mem_write", {31'b0, bus.out_mem_write}, 32'd1);
      chk("sw_B_imm", bus.B, 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and operand-select stage that sits directly upstream of the ALU. Each cycle it captures one decoded instruction and forwards newer results into its operands. It decodes ALUOp/funct into the 4-bit ALU control code and presents registered A, B and ALUcontrol to the ALU. It also detects load-use hazards, inserts bubbles, and honours hold and flush requests from the pipeline control.

## Interface
- No parameters; datapath width fixed at 32 bits, register index 5 bits.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode slot holds a real instruction.
- rs_data, rt_data  in  32  register-file read data.
- imm  in  32  sign-extended immediate.
- rs, rt, rd  in  5  source/destination register indices.
- alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 slt-immediate.
- funct  in  6  R-type function field.
- alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg  in  1 each  decoded controls.
- hold  in  1  downstream not ready; freeze stage contents.
- flush  in  1  discard captured instruction (branch taken).
- exm_reg_write, exm_rd, exm_result  in  1/5/32  EX/MEM writeback candidate.
- wb_reg_write, wb_rd, wb_result  in  1/5/32  MEM/WB writeback candidate.
- A, B  out  32  registered ALU operands.
- ALUcontrol  out  4  registered ALU operation code.
- store_data  out  32  registered forwarded rt value for stores.
- dest  out  5  registered destination (rd if reg_dst else rt).
- out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  out  1 each  registered controls.
- hazard_stall  out  1  combinational; decode and PC must hold this cycle.
- illegal_funct  out  1  registered; valid R-type with unsupported funct.

## Operation
- Update priority per rising edge: rst > flush > hold > hazard bubble > capture.
- Reset (async): every registered output goes to 0, including A, B, store_data, dest and ALUcontrol=0000. out_valid=0.
- flush: load a bubble. out_valid and all out_* controls are 0, illegal_funct is 0, datapath registers are don't-care (drive 0).
- hold (no flush): all registers keep their values and hazard_stall stays combinationally evaluated.
- Load-use hazard: hazard_stall=1 when out_valid & out_mem_read & in_valid & dest!=0 & (dest==rs | (dest==rt & !alu_src) | (dest==rt & mem_write)). When it is set and neither flush nor hold is active, load a bubble. Decode re-presents the same instruction next cycle.
- Capture: register all controls with out_valid=in_valid. If in_valid=0, force out_reg_write/out_mem_read/out_mem_write to 0.
- Forwarding applies to each source index s (rs, rt):
  - If exm_reg_write & exm_rd==s & s!=0, use exm_result.
  - Else if wb_reg_write & wb_rd==s & s!=0, use wb_result.
  - Else use the register-file data.
  - Register $0 always reads rs_data/rt_data unmodified.
- A = forwarded rs. B = imm if alu_src, else forwarded rt. store_data = forwarded rt, regardless of alu_src.
- ALUcontrol decode:
  - alu_op 00 gives 0010; 01 gives 0110; 11 gives 0111.
  - alu_op 10 with funct 100000 gives 0010; 100010 gives 0110; 100100 gives 0000; 100101 gives 0001; 101010 gives 0111.
  - Any other funct gives 0010 with illegal_funct=1, registered alongside. The instruction still passes with out_valid=1.

## Timing
- Latency: decode inputs appear on outputs one cycle after the capturing edge. The ALU samples A/B/ALUcontrol on the following edge.
- hazard_stall is combinational from current registered state and current decode inputs, with no register in the path. It is asserted for exactly one cycle per load-use pair, unless hold extends it.
- hold and hazard together: hold wins, so the stage freezes and no bubble is inserted. The hazard re-evaluates after hold drops.
- flush and hazard together: flush wins and the bubble is loaded. hazard_stall may still be 1 that cycle.
- Reset asserted mid-hold or mid-bubble clears immediately, without waiting for clk. The first capture happens on the first edge after rst deasserts.

## Test plan
- Reset: assert rst mid-run, then check all outputs are 0 and out_valid=0 with no clock edge. Release rst, then drive add (alu_op 10, funct 100000, rs_data=5, rt_data=7) and check A=5, B=7, ALUcontrol=0010, out_valid=1 one cycle later.
- Decode sweep: for each funct (and/or/sub/slt/0x3F) check ALUcontrol is 0000/0001/0110/0111/0010 respectively, and illegal_funct=1 only for 0x3F. Check alu_op 00/01/11 give 0010/0110/0111.
- Forwarding: rs=3 with exm_rd=3/exm_result=0xAAAA0000 and wb_rd=3/wb_result=0x5555 gives A=0xAAAA0000. With exm_reg_write=0, A=0x5555. With rs=0 and both writers targeting 0, A=rs_data.
- Load-use: lw to $4, then add using rs=4. hazard_stall=1 for one cycle, the next output is a bubble (out_valid=0, out_reg_write=0), then the add is captured with wb forwarding.
- hold/flush: hold for 3 cycles and check outputs are frozen. Assert flush together with hold and check a bubble loads. Assert hazard with flush and check the bubble and that out_mem_write=0.
